accel_core_booth_mul: RTL and testbench



---
 rtl/accel_core_pkg.sv | 14 +
 rtl/accel_core_booth_step.sv | 33 +++
 rtl/accel_core_booth_mul.sv | 65 ++++++
 tb/tb_accel_core_booth_mul.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/accel_core_pkg.sv
// Shared accel_core types: operand width and the Booth pipeline stage payload.
package accel_core_pkg;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned MUL_LATENCY = WIDTH;
  localparam int unsigned AQQ_W       = 2 * WIDTH + 1;

  // aqq_0 = {A, Q, q_-1}; mu = multiplicand carried alongside
  typedef struct packed {
    logic [AQQ_W-1:0] aqq_0;
    logic [WIDTH-1:0] mu;
  } stage_mul_inp_t;

endpackage

// File: rtl/accel_core_booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M into A, then arithmetic shift right.
module accel_core_booth_step
  import accel_core_pkg::*;
(
  input  stage_mul_inp_t stage_i,
  output stage_mul_inp_t stage_o
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   a_sum;

  always_comb begin
    a     = stage_i.aqq_0[2*WIDTH:WIDTH+1];
    q     = stage_i.aqq_0[WIDTH:1];
    q_1   = stage_i.aqq_0[0];
    a_ext = {a[WIDTH-1], a};
    m_ext = {stage_i.mu[WIDTH-1], stage_i.mu};
    a_sum = a_ext;
    case ({q[0], q_1})
      2'b01:   a_sum = a_ext + m_ext;
      2'b10:   a_sum = a_ext - m_ext;
      default: a_sum = a_ext;
    endcase
    // The W+1-bit sum keeps M = -2^(W-1) exact; dropping its duplicated sign after the shift is lossless.
    stage_o.aqq_0 = {a_sum, q};
    stage_o.mu    = stage_i.mu;
  end

endmodule

// File: rtl/accel_core_booth_mul.sv
// Fixed-depth signed Booth multiplier pipeline with one global advance for valid/ready flow control.
module accel_core_booth_mul
  import accel_core_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rst_N,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int unsigned LAST = MUL_LATENCY - 1;

  stage_mul_inp_t             s_q [MUL_LATENCY];
  stage_mul_inp_t             s_d [MUL_LATENCY];
  logic [MUL_LATENCY-1:0]     v_q;
  stage_mul_inp_t             entry;
  logic                       adv;

  // Whole pipe moves together; a bubble in the last stage never blocks.
  assign adv     = !v_q[LAST] | OutReady;
  assign InReady = adv;

  always_comb begin
    entry.aqq_0 = {{WIDTH{1'b0}}, Multiplier, 1'b0};
    entry.mu    = Multiplicand;
  end

  for (genvar k = 0; k < MUL_LATENCY; k++) begin : g_step
    if (k == 0) begin : g_first
      accel_core_booth_step u_step (
        .stage_i (entry),
        .stage_o (s_d[k])
      );
    end else begin : g_mid
      accel_core_booth_step u_step (
        .stage_i (s_q[k-1]),
        .stage_o (s_d[k])
      );
    end
  end

  // Stage data loads even for bubbles; only v_q marks meaning.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      for (int k = 0; k < MUL_LATENCY; k++) begin
        s_q[k] <= '0;
      end
      v_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < MUL_LATENCY; k++) begin
        s_q[k] <= s_d[k];
      end
      v_q <= {v_q[LAST-1:0], InValid};
    end
  end

  assign OutValid = v_q[LAST];
  assign Product  = s_q[LAST].aqq_0[2*WIDTH:1];

endmodule

// File: tb/tb_accel_core_booth_mul.sv
// Directed bench for accel_core_booth_mul: single products, corners, streaming, backpressure, bubbles, reset.
module tb_accel_core_booth_mul;

  logic        Clk;
  logic        Rst_N;
  logic        InValid;
  logic        InReady;
  logic [7:0]  Multiplicand;
  logic [7:0]  Multiplier;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] Product;

  int n_vec = 0;
  int n_err = 0;

  accel_core_booth_mul dut (
    .Clk          (Clk),
    .Rst_N        (Rst_N),
    .InValid      (InValid),
    .InReady      (InReady),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .Product      (Product)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one op, check it stays invisible for 7 edges, then appears on the 8th with the right value.
  task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    @(negedge Clk);
    InValid = 1'b1; Multiplicand = a; Multiplier = b; OutReady = 1'b1;
    #1 chk({tag, "_inready"}, 16'(InReady), 16'h1);
    @(negedge Clk);
    InValid = 1'b0;
    repeat (6) @(negedge Clk);
    #1 chk({tag, "_early"}, 16'(OutValid), 16'h0);
    @(negedge Clk);
    #1 chk({tag, "_valid"}, 16'(OutValid), 16'h1);
    chk({tag, "_product"}, Product, exp);
    @(negedge Clk);
  endtask

  // Feeds n random ops; gap toggles InValid; stall_len drops OutReady once the first result shows.
  task automatic stream(input string tag, input int n, input bit gap, input int stall_len);
    logic [7:0]  op_a [64];
    logic [7:0]  op_b [64];
    logic [15:0] exp_q [$];
    bit          acc_hist [512];
    logic [15:0] held;
    logic signed [15:0] p;
    int idx = 0, cyc = 0, stall_cnt = 0, outs = 0;
    bit stalled_once = 1'b0;
    for (int i = 0; i < n; i++) begin
      op_a[i] = 8'($urandom);
      op_b[i] = 8'($urandom);
    end
    op_a[0] = 8'h80; op_b[0] = 8'h80;
    held = '0;
    @(negedge Clk);
    while ((idx < n || exp_q.size() > 0) && cyc < 300) begin
      if (stall_len > 0 && !stalled_once && OutValid) begin
        stalled_once = 1'b1;
        stall_cnt    = stall_len;
        held         = Product;
      end
      OutReady     = (stall_cnt == 0);
      InValid      = (idx < n) && (!gap || (cyc % 2 == 0));
      Multiplicand = op_a[idx % 64];
      Multiplier   = op_b[idx % 64];
      #1;
      if (stall_cnt > 0) begin
        chk({tag, "_stall_inready"}, 16'(InReady), 16'h0);
        chk({tag, "_stall_hold"}, Product, held);
      end else if (stall_len == 0) begin
        chk({tag, "_pattern"}, 16'(OutValid), (cyc >= 8) ? 16'(acc_hist[cyc-8]) : 16'h0);
        if (!gap && idx < n) chk({tag, "_inready"}, 16'(InReady), 16'h1);
      end
      if (OutValid && OutReady) begin
        outs++;
        if (exp_q.size() == 0) chk({tag, "_extra_out"}, Product, 16'hxxxx);
        else chk({tag, "_product"}, Product, exp_q.pop_front());
      end
      acc_hist[cyc] = InValid && InReady;
      if (InValid && InReady) begin
        p = $signed(op_a[idx % 64]) * $signed(op_b[idx % 64]);
        exp_q.push_back(p);
        idx++;
      end
      if (stall_cnt > 0) stall_cnt--;
      cyc++;
      @(negedge Clk);
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    chk({tag, "_out_count"}, 16'(outs), 16'(n));
  endtask

  initial begin
    Rst_N = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    Multiplicand = '0; Multiplier = '0;
    #12;
    chk("rst_outvalid", 16'(OutValid), 16'h0);
    chk("rst_product", Product, 16'h0);
    chk("rst_inready", 16'(InReady), 16'h1);
    @(negedge Clk);
    Rst_N = 1'b1;

    single("p3x5",    8'd3,    8'd5,    16'h000F);
    single("m7x6",    8'hF9,   8'd6,    16'hFFD6);
    single("z0xm1",   8'd0,    8'hFF,   16'h0000);
    single("m128sq",  8'h80,   8'h80,   16'h4000);
    single("m128x127",8'h80,   8'h7F,   16'hC080);
    single("p127sq",  8'h7F,   8'h7F,   16'h3F01);
    single("m1xm1",   8'hFF,   8'hFF,   16'h0001);

    stream("stream", 20, 1'b0, 0);
    stream("bp",     10, 1'b0, 5);
    stream("bubble",  8, 1'b1, 0);

    // Fill the pipe with 4 ops, then reset while they are in flight.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      InValid = 1'b1; Multiplicand = 8'(i + 9); Multiplier = 8'(i + 3);
    end
    @(negedge Clk);
    InValid = 1'b0;
    Rst_N   = 1'b0;
    #1 chk("midrst_outvalid", 16'(OutValid), 16'h0);
    chk("midrst_product", Product, 16'h0);
    @(negedge Clk);
    Rst_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      #1 chk("midrst_stale", 16'(OutValid), 16'h0);
    end
    single("p2xm3", 8'd2, 8'hFD, 16'hFFFA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
